// File: rtl/sdram_map_pkg.sv
// SDRAM memory map shared by the loader (writer) and the network's read path.
// Regions are packed back to back from BASE_ADDR: image, L0, L1, L2.
package sdram_map_pkg;

  localparam int IMSIZE = 128;
  localparam int L0SIZE = 2048;
  localparam int L1SIZE = 256;
  localparam int L2SIZE = 160;

  localparam int IM_OFFSET = 0;
  localparam int L0_OFFSET = IM_OFFSET + IMSIZE;
  localparam int L1_OFFSET = L0_OFFSET + L0SIZE;
  localparam int L2_OFFSET = L1_OFFSET + L1SIZE;

  // Wide enough to hold the largest region length itself, not just its last index.
  localparam int CNT_W = $clog2(L0SIZE + 1);

  typedef enum logic [1:0] {
    L0    = 2'b00,
    L1    = 2'b01,
    L2    = 2'b10,
    IMAGE = 2'b11
  } region_e;

  typedef struct packed {
    logic [CNT_W-1:0] offset;
    logic [CNT_W-1:0] size;
  } region_info_t;

  function automatic region_info_t region_info(input region_e r);
    region_info_t ri;
    case (r)
      L0:      begin ri.offset = CNT_W'(L0_OFFSET); ri.size = CNT_W'(L0SIZE); end
      L1:      begin ri.offset = CNT_W'(L1_OFFSET); ri.size = CNT_W'(L1SIZE); end
      L2:      begin ri.offset = CNT_W'(L2_OFFSET); ri.size = CNT_W'(L2SIZE); end
      default: begin ri.offset = CNT_W'(IM_OFFSET); ri.size = CNT_W'(IMSIZE); end
    endcase
    return ri;
  endfunction

endpackage

// File: rtl/sdram_loader_byte_fifo.sv
// Small synchronous FIFO with registered storage; head is read straight from the
// storage array, so a pushed byte is visible on head only from the next cycle.
module byte_fifo #(
  parameter int DEPTH = 4,   // power of 2, at least 2
  parameter int WIDTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/sdram_loader.sv
// Avalon-MM write master: streams one region's bytes through a small FIFO into
// consecutive SDRAM byte addresses, one single-byte write per accepted beat.
module sdram_loader
  import sdram_map_pkg::*;
#(
  parameter int MASTER_ADDRESSWIDTH = 26,
  parameter int DATAWIDTH           = 8,
  parameter int BASE_ADDR           = 0,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           load_start,
  input  logic [1:0]                     which_data,
  input  logic                           abort,
  input  logic [DATAWIDTH-1:0]           in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           busy,
  output logic                           done,
  output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
  output logic [DATAWIDTH-1:0]           master_writedata,
  output logic                           master_write,
  output logic                           master_read,
  input  logic                           master_waitrequest
);

  localparam int MAW = MASTER_ADDRESSWIDTH;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, FINISH, ABORT} state_e;

  state_e           state, state_nxt;
  logic [MAW-1:0]   wr_addr;
  logic [CNT_W-1:0] size, acc_cnt, wr_cnt;
  logic             stall_hold;
  region_info_t     ri;

  logic [DATAWIDTH-1:0] fifo_head;
  logic                 fifo_full, fifo_empty;
  logic [FCW-1:0]       fifo_count;
  logic                 wr_req, wr_fire, push, flush, last_wr, last_acc;

  assign ri = region_info(region_e'(which_data));

  // In ABORT only a write that was already stalled may still be presented.
  assign wr_req   = ((state == LOAD || state == DRAIN) && !fifo_empty) ||
                    (state == ABORT && stall_hold);
  assign wr_fire  = wr_req && !master_waitrequest;
  assign push     = in_valid && in_ready && !fifo_full;
  assign last_wr  = wr_fire && ((wr_cnt + 1'b1) == size);
  assign last_acc = push && ((acc_cnt + 1'b1) == size);
  assign flush    = (state == ABORT) && (state_nxt == IDLE);

  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATAWIDTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (push),
    .din     (in_data),
    .pop     (wr_fire),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (load_start) state_nxt = LOAD;
      LOAD: begin
        if      (abort)    state_nxt = ABORT;
        else if (last_wr)  state_nxt = FINISH;
        else if (last_acc) state_nxt = DRAIN;
      end
      DRAIN: begin
        if      (abort)   state_nxt = ABORT;
        else if (last_wr) state_nxt = FINISH;
      end
      FINISH: state_nxt = IDLE;
      ABORT:  if (!stall_hold || !master_waitrequest) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready         = (state == LOAD) && !abort &&
                       (fifo_count < FCW'(FIFO_DEPTH)) && (acc_cnt < size);
    busy             = (state != IDLE);
    done             = (state == FINISH);
    master_write     = wr_req;
    master_address   = wr_req ? wr_addr : '0;
    master_writedata = wr_req ? fifo_head : '0;
    master_read      = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr    <= '0;
      size       <= '0;
      acc_cnt    <= '0;
      wr_cnt     <= '0;
      stall_hold <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (load_start) begin
          wr_addr <= MAW'(BASE_ADDR) + MAW'(ri.offset);
          size    <= ri.size;
          acc_cnt <= '0;
          wr_cnt  <= '0;
        end
      end else begin
        if (push) acc_cnt <= acc_cnt + 1'b1;
        if (wr_fire) begin
          wr_addr <= wr_addr + 1'b1;
          wr_cnt  <= wr_cnt + 1'b1;
        end
      end
      // Remembers whether a write is stuck on waitrequest, so ABORT can finish it.
      stall_hold <= (state != ABORT) ? (wr_req && master_waitrequest)
                                     : (stall_hold && master_waitrequest);
    end
  end

endmodule

// File: tb/tb_sdram_loader.sv
// Bench for sdram_loader: table of region loads checked against a queue-based
// model of the expected write stream, plus abort and mid-transfer reset sequences.
module tb_sdram_loader;

  localparam int MAW  = 26;
  localparam int BASE = 'h10000;

  logic           clk = 1'b0, reset_n = 1'b0;
  logic           load_start = 1'b0, abort = 1'b0, in_valid = 1'b0, master_waitrequest = 1'b0;
  logic [1:0]     which_data = 2'b00;
  logic [7:0]     in_data = 8'h00;
  logic           in_ready, busy, done, master_write, master_read;
  logic [MAW-1:0] master_address;
  logic [7:0]     master_writedata;

  sdram_loader #(.MASTER_ADDRESSWIDTH(MAW), .DATAWIDTH(8), .BASE_ADDR(BASE), .FIFO_DEPTH(4)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .load_start         (load_start),
    .which_data         (which_data),
    .abort              (abort),
    .in_data            (in_data),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .busy               (busy),
    .done               (done),
    .master_address     (master_address),
    .master_writedata   (master_writedata),
    .master_write       (master_write),
    .master_read        (master_read),
    .master_waitrequest (master_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    int region, vprob, stall_every, stall_len, one_shot, restart_at, stop_at;
    int exp_writes, exp_first, exp_last, exp_maxq;
  } vec_t;

  typedef struct {
    logic [MAW-1:0] a;
    logic [7:0]     d;
  } wr_t;

  // Memory map as seen from outside, indexed by which_data.
  int reg_off[4] = '{128, 2176, 2432, 0};
  int reg_sz[4]  = '{2048, 256, 160, 128};

  int n_chk = 0, n_fail = 0;
  int cyc = 0, acc = 0, cur_size = 0, n_wr = 0, last_wr_cyc = 0, done_cnt = 0, maxq = 0, stall_left = 0;
  bit ld_active = 0, stalled_cur = 0, prev_stall = 0, hs_last = 0;
  logic [MAW-1:0] cur_base = '0, first_addr = '0, last_addr = '0, prev_addr = '0;
  logic [7:0]     prev_data = '0;
  wr_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // One clock: sample and check at negedge, return just after the next posedge.
  task automatic step();
    wr_t e;
    @(negedge clk);
    cyc++;
    chk("in_ready", int'(in_ready),
        int'(ld_active && acc < cur_size && exp_q.size() < 4 && !abort));
    if (ld_active) begin
      chk("busy", int'(busy), 1);
      chk("master_write", int'(master_write), int'(exp_q.size() != 0));
    end
    chk("master_read", int'(master_read), 0);
    if (exp_q.size() > maxq) maxq = exp_q.size();
    if (prev_stall) begin
      chk("stall_write", int'(master_write), 1);
      chk("stall_addr", int'(master_address), int'(prev_addr));
      chk("stall_data", int'(master_writedata), int'(prev_data));
    end
    if (!master_write) chk("idle_bus", int'({master_address, master_writedata}), 0);
    if (master_write && !master_waitrequest) begin
      if (exp_q.size() == 0) chk("unexpected_write", int'(master_write), 0);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", int'(master_address), int'(e.a));
        chk("wr_data", int'(master_writedata), int'(e.d));
      end
      if (n_wr == 0) first_addr = master_address;
      last_addr = master_address;
      n_wr++;
      last_wr_cyc = cyc;
      stalled_cur = 0;
    end
    hs_last = in_valid && in_ready;
    if (hs_last) begin
      exp_q.push_back('{cur_base + MAW'(acc), in_data});
      acc++;
    end
    if (done) begin
      done_cnt++;
      chk("done_latency", cyc, last_wr_cyc + 1);
      ld_active = 0;
    end
    prev_stall = master_write && master_waitrequest;
    prev_addr  = master_address;
    prev_data  = master_writedata;
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input vec_t v);
    bit restarted = 0;
    int guard;
    cur_base = MAW'(BASE + reg_off[v.region]);
    cur_size = reg_sz[v.region];
    acc = 0; n_wr = 0; done_cnt = 0; maxq = 0; stall_left = 0; stalled_cur = 0;
    exp_q.delete();
    which_data = 2'(v.region);
    load_start = 1; in_valid = 0; master_waitrequest = 0;
    step();
    load_start = 0;
    ld_active = 1;
    for (guard = 0; guard < 20000; guard++) begin
      if (stall_left > 0) begin
        master_waitrequest = 1; stall_left--;
      end else if (master_write && !stalled_cur &&
                   ((v.stall_every > 0 && (n_wr % v.stall_every) == v.stall_every - 1) ||
                    n_wr == v.one_shot)) begin
        master_waitrequest = 1; stall_left = v.stall_len - 1; stalled_cur = 1;
      end else master_waitrequest = 0;
      if (!(in_valid && !hs_last))
        in_valid = (acc < cur_size) &&
                   (master_waitrequest || $urandom_range(99) < 32'(v.vprob));
      in_data = (v.region == 3) ? 8'(acc) : 8'(acc * 37 + v.region * 11);
      if (v.restart_at >= 0 && !restarted && acc >= v.restart_at) begin
        load_start = 1; which_data = 2'b00; restarted = 1;
      end else load_start = 0;
      step();
      if (done_cnt > 0) break;
      if (v.stop_at >= 0 && acc >= v.stop_at) return;
    end
    in_valid = 0; load_start = 0; master_waitrequest = 0;
    chk("load_done", done_cnt, 1);
    step();
    chk("busy_after_done", int'(busy), 0);
    chk("done_one_cycle", int'(done), 0);
  endtask

  task automatic check_result(input vec_t v);
    chk("writes", n_wr, v.exp_writes);
    chk("first_addr", int'(first_addr) - BASE, v.exp_first);
    chk("last_addr", int'(last_addr) - BASE, v.exp_last);
    chk("model_queue_empty", exp_q.size(), 0);
    if (v.exp_maxq >= 0) chk("fifo_peak", maxq, v.exp_maxq);
  endtask

  vec_t vec[5];
  vec_t vx;
  int   nw0;

  initial begin
    // region, vprob, stall_every, stall_len, one_shot, restart_at, stop_at, writes, first, last, peak
    vec[0] = '{3, 100, 0, 1,  -1, -1, -1,  128,    0,  127,  1};
    vec[1] = '{2, 100, 4, 3,  -1, -1, -1,  160, 2432, 2591, -1};
    vec[2] = '{0,  60, 0, 10, 100, -1, -1, 2048,  128, 2175,  4};
    vec[3] = '{3,  80, 0, 1,  -1, 50, -1,  128,    0,  127,  1};
    vec[4] = '{1,  50, 7, 2,  -1, -1, -1,  256, 2176, 2431, -1};

    #3;
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_write", int'(master_write), 0);
    chk("reset_addr", int'(master_address), 0);
    chk("reset_data", int'(master_writedata), 0);
    chk("reset_read", int'(master_read), 0);
    @(posedge clk); #1;
    reset_n = 1;
    step();

    for (int i = 0; i < 5; i++) begin
      run_load(vec[i]);
      check_result(vec[i]);
      repeat (2) step();
    end

    // Abort in L1 after 20 bytes while a write is stalled.
    vx = vec[4];
    vx.vprob = 100; vx.stall_every = 0; vx.stop_at = 20;
    run_load(vx);
    in_valid = 0;
    for (int k = 0; k < 10 && !master_write; k++) step();
    chk("abort_setup_write", int'(master_write), 1);
    abort = 1; master_waitrequest = 1; in_valid = 1; in_data = 8'hEE;
    nw0 = n_wr;
    step();
    abort = 0; in_valid = 0; ld_active = 0;
    step(); step();
    master_waitrequest = 0;
    step();
    exp_q.delete();
    repeat (6) step();
    chk("abort_writes", n_wr - nw0, 1);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_busy", int'(busy), 0);
    run_load(vec[4]);
    check_result(vec[4]);
    repeat (2) step();

    // Reset mid-L0 while a write is presented.
    vx = vec[2];
    vx.vprob = 100; vx.one_shot = -1; vx.stop_at = 30;
    run_load(vx);
    in_valid = 0;
    for (int k = 0; k < 10 && !master_write; k++) step();
    chk("reset_setup_write", int'(master_write), 1);
    reset_n = 0;
    #1;
    chk("midreset_in_ready", int'(in_ready), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_done", int'(done), 0);
    chk("midreset_write", int'(master_write), 0);
    chk("midreset_addr", int'(master_address), 0);
    chk("midreset_data", int'(master_writedata), 0);
    chk("midreset_read", int'(master_read), 0);
    exp_q.delete(); ld_active = 0; prev_stall = 0;
    @(posedge clk); #1;
    repeat (2) step();
    reset_n = 1;
    step();
    run_load(vec[0]);
    check_result(vec[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
